// File: rtl/frame_packer.sv
// frame_packer: pops payload bytes from the prefetch FIFO and streams them
// out as framed packets: HDR0, HDR1, SEQ, LEN, payload, CHK.
// The output stage is a single register behind a valid/ready handshake.
module frame_packer #(
    parameter int         PAYLOAD_LEN = 32,
    parameter logic [7:0] HDR0        = 8'h55,
    parameter logic [7:0] HDR1        = 8'hAA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       fifo_rd_vld,
    input  logic [7:0] fifo_rd_data,
    output logic       fifo_rd_en,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] seq_num
);

    // State names the next frame byte to be loaded into the output register
    typedef enum logic [2:0] {
        S_IDLE,
        S_H1,
        S_SQ,
        S_LN,
        S_PL,
        S_CK
    } state_t;

    localparam logic [7:0] LEN_BYTE = 8'(PAYLOAD_LEN);
    localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] chk;
    logic [7:0] chk_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic [7:0] seq_nxt;
    logic [7:0] load_byte;
    logic       load;
    logic       busy_nxt;
    logic       done_nxt;
    logic       out_free;

    assign out_free = !tx_valid || tx_ready;

    // Next-state logic: decide which byte (if any) enters the output register this cycle
    always_comb begin
        state_nxt  = state;
        chk_nxt    = chk;
        cnt_nxt    = cnt;
        seq_nxt    = seq_num;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        load       = 1'b0;
        load_byte  = 8'h00;
        fifo_rd_en = 1'b0;
        case (state)
            S_IDLE: begin
                if (out_free && en && fifo_rd_vld) begin
                    load      = 1'b1;
                    load_byte = HDR0;
                    busy_nxt  = 1'b1;
                    state_nxt = S_H1;
                end
            end
            S_H1: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_byte = HDR1;
                    state_nxt = S_SQ;
                end
            end
            S_SQ: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_byte = seq_num;
                    chk_nxt   = seq_num;
                    state_nxt = S_LN;
                end
            end
            S_LN: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_byte = LEN_BYTE;
                    chk_nxt   = chk + LEN_BYTE;
                    cnt_nxt   = 8'h00;
                    state_nxt = S_PL;
                end
            end
            S_PL: begin
                if (out_free && fifo_rd_vld && !rst) begin
                    fifo_rd_en = 1'b1;
                    load       = 1'b1;
                    load_byte  = fifo_rd_data;
                    chk_nxt    = chk + fifo_rd_data;
                    cnt_nxt    = cnt + 8'd1;
                    if (cnt == LAST_IDX) begin
                        state_nxt = S_CK;
                    end
                end
            end
            S_CK: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_byte = chk;
                    seq_nxt   = seq_num + 8'd1;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, accumulator and output register; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            chk        <= 8'h00;
            cnt        <= 8'h00;
            seq_num    <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            state      <= state_nxt;
            chk        <= chk_nxt;
            cnt        <= cnt_nxt;
            seq_num    <= seq_nxt;
            busy       <= busy_nxt;
            frame_done <= done_nxt;
            if (load) begin
                tx_valid <= 1'b1;
                tx_data  <= load_byte;
            end else if (out_free) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_packer.sv
// tb_frame_packer: scoreboard bench for frame_packer with a 4-byte payload.
// A queue models the prefetch FIFO; expected frame bytes are queued as each
// frame's payload is pushed and matched against bytes the DUT hands over.
module tb_frame_packer;

    localparam int PLEN = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       fifo_rd_vld;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd_en;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       frame_done;
    logic [7:0] seq_num;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    int         errors     = 0;
    int         checks     = 0;
    int         tick_cnt   = 0;
    int         pop_cnt    = 0;
    int         done_cnt   = 0;
    int         done_tick  = 0;
    int         hold_viol  = 0;
    int         rd_viol    = 0;
    bit         bp_mode    = 1'b0;
    bit         starve     = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [7:0] exp_seq    = 8'h00;

    frame_packer #(.PAYLOAD_LEN(PLEN), .HDR0(8'h55), .HDR1(8'hAA)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .fifo_rd_vld  (fifo_rd_vld),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .frame_done   (frame_done),
        .seq_num      (seq_num)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Watchdog so a stuck run still ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_fifo();
        fifo_rd_vld  = (fifo_q.size() > 0) && !starve;
        fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    endtask

    // One clock: observe on the falling edge, update FIFO model and inputs after the rising edge
    task automatic tick();
        bit         fire;
        logic [3:0] pat;
        pat = 4'b1001;
        tick_cnt++;
        @(negedge clk);
        if (prev_stall && (!tx_valid || tx_data !== prev_data)) hold_viol++;
        if (fifo_rd_en && tx_valid && !tx_ready) rd_viol++;
        if (tx_valid && tx_ready) obs_q.push_back(tx_data);
        if (fifo_rd_en) pop_cnt++;
        if (frame_done) begin
            done_cnt++;
            done_tick = tick_cnt;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        fire       = fifo_rd_en;
        @(posedge clk);
        #1;
        if (fire && fifo_q.size() > 0) void'(fifo_q.pop_front());
        tx_ready = bp_mode ? pat[tick_cnt % 4] : 1'b1;
        drive_fifo();
    endtask

    // Queue one frame's payload into the FIFO and its full expected byte stream
    task automatic push_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        logic [7:0] pay[4];
        int         sum;
        pay = '{a, b, c, d};
        sum = int'(exp_seq) + PLEN;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        exp_q.push_back(exp_seq);
        exp_q.push_back(8'(PLEN));
        for (int i = 0; i < 4; i++) begin
            fifo_q.push_back(pay[i]);
            exp_q.push_back(pay[i]);
            sum = sum + int'(pay[i]);
        end
        exp_q.push_back(sum[7:0]);
        exp_seq = exp_seq + 8'd1;
        drive_fifo();
    endtask

    task automatic run_until_drained(input int bound, output bit timed_out);
        int n;
        n         = 0;
        timed_out = 1'b0;
        while (obs_q.size() < exp_q.size()) begin
            if (n >= bound) begin
                timed_out = 1'b1;
                break;
            end
            tick();
            n++;
        end
        en = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        en       = 1'b0;
        tx_ready = 1'b1;
        starve   = 1'b0;
        drive_fifo();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %02h expected 00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
        checks++; if (seq_num !== 8'h00) begin errors++; $display("[TB] FAIL reset_seq_num: got %02h expected 00", seq_num); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_fifo_rd_en: got %b expected 0", fifo_rd_en); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic_frame();
        int         t0, p0, d0;
        bit         to;
        logic [7:0] eb, gb;
        push_frame(8'h01, 8'h02, 8'h03, 8'h04);
        p0 = pop_cnt; d0 = done_cnt; t0 = tick_cnt;
        en = 1'b1;
        run_until_drained(40, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL basic_timeout: got %0d bytes expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL basic_stream: got none expected %02h", eb); end
            else begin gb = obs_q.pop_front(); if (gb !== eb) begin errors++; $display("[TB] FAIL basic_stream: got %02h expected %02h", gb, eb); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL basic_extra: got %0d extra bytes expected 0", obs_q.size()); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL basic_done_pulses: got %0d expected 1", done_cnt - d0); end
        checks++; if (pop_cnt - p0 != PLEN) begin errors++; $display("[TB] FAIL basic_pops: got %0d expected %0d", pop_cnt - p0, PLEN); end
        checks++; if (done_tick - t0 != PLEN + 6) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected %0d", done_tick - t0, PLEN + 6); end
        checks++; if (seq_num !== 8'h01) begin errors++; $display("[TB] FAIL basic_seq: got %02h expected 01", seq_num); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy: got %b expected 0", busy); end
    endtask

    task automatic test_second_frame();
        bit         to;
        logic [7:0] eb, gb;
        push_frame(8'h05, 8'h06, 8'h07, 8'h08);
        en = 1'b1;
        run_until_drained(40, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL second_timeout: got %0d bytes expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL second_stream: got none expected %02h", eb); end
            else begin gb = obs_q.pop_front(); if (gb !== eb) begin errors++; $display("[TB] FAIL second_stream: got %02h expected %02h", gb, eb); end end
        end
        checks++; if (seq_num !== 8'h02) begin errors++; $display("[TB] FAIL second_seq: got %02h expected 02", seq_num); end
    endtask

    task automatic test_back_to_back();
        int         t0, d0;
        bit         to;
        logic [7:0] eb, gb;
        push_frame(8'h10, 8'h20, 8'h30, 8'h40);
        push_frame(8'hC0, 8'hD0, 8'hE0, 8'hF0);
        d0 = done_cnt; t0 = tick_cnt;
        en = 1'b1;
        run_until_drained(80, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL b2b_timeout: got %0d bytes expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL b2b_stream: got none expected %02h", eb); end
            else begin gb = obs_q.pop_front(); if (gb !== eb) begin errors++; $display("[TB] FAIL b2b_stream: got %02h expected %02h", gb, eb); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL b2b_extra: got %0d extra bytes expected 0", obs_q.size()); end
        checks++; if (done_cnt - d0 != 2) begin errors++; $display("[TB] FAIL b2b_done_pulses: got %0d expected 2", done_cnt - d0); end
        checks++; if (done_tick - t0 != 2 * (PLEN + 5) + 1) begin errors++; $display("[TB] FAIL b2b_timing: got %0d expected %0d", done_tick - t0, 2 * (PLEN + 5) + 1); end
        checks++; if (seq_num !== exp_seq) begin errors++; $display("[TB] FAIL b2b_seq: got %02h expected %02h", seq_num, exp_seq); end
    endtask

    task automatic test_backpressure();
        bit         to;
        logic [7:0] eb, gb;
        hold_viol = 0;
        rd_viol   = 0;
        bp_mode   = 1'b1;
        push_frame(8'h11, 8'h22, 8'h33, 8'h44);
        en = 1'b1;
        run_until_drained(120, to);
        bp_mode  = 1'b0;
        tx_ready = 1'b1;
        checks++; if (to) begin errors++; $display("[TB] FAIL bp_timeout: got %0d bytes expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL bp_stream: got none expected %02h", eb); end
            else begin gb = obs_q.pop_front(); if (gb !== eb) begin errors++; $display("[TB] FAIL bp_stream: got %02h expected %02h", gb, eb); end end
        end
        checks++; if (hold_viol != 0) begin errors++; $display("[TB] FAIL bp_hold: got %0d unstable stall cycles expected 0", hold_viol); end
        checks++; if (rd_viol != 0) begin errors++; $display("[TB] FAIL bp_pop_while_stalled: got %0d expected 0", rd_viol); end
        checks++; if (seq_num !== exp_seq) begin errors++; $display("[TB] FAIL bp_seq: got %02h expected %02h", seq_num, exp_seq); end
    endtask

    task automatic test_underflow();
        int         p0, n;
        bit         to;
        logic [7:0] eb, gb;
        push_frame(8'h9A, 8'hBC, 8'hDE, 8'hF1);
        p0 = pop_cnt;
        n  = 0;
        en = 1'b1;
        while (pop_cnt - p0 < 2 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (pop_cnt - p0 != 2) begin errors++; $display("[TB] FAIL uf_reach_payload1: got %0d pops expected 2", pop_cnt - p0); end
        starve = 1'b1;
        drive_fifo();
        repeat (10) tick();
        checks++; if (pop_cnt - p0 != 2) begin errors++; $display("[TB] FAIL uf_no_pop: got %0d pops expected 2", pop_cnt - p0); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL uf_valid_drop: got %b expected 0", tx_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL uf_busy: got %b expected 1", busy); end
        starve = 1'b0;
        drive_fifo();
        run_until_drained(40, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL uf_timeout: got %0d bytes expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL uf_stream: got none expected %02h", eb); end
            else begin gb = obs_q.pop_front(); if (gb !== eb) begin errors++; $display("[TB] FAIL uf_stream: got %02h expected %02h", gb, eb); end end
        end
    endtask

    task automatic test_reset_mid_frame();
        int p0, n;
        push_frame(8'h01, 8'h01, 8'h01, 8'h01);
        p0 = pop_cnt;
        n  = 0;
        en = 1'b1;
        while (pop_cnt - p0 < 2 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (pop_cnt - p0 != 2) begin errors++; $display("[TB] FAIL rmf_reach_pl: got %0d pops expected 2", pop_cnt - p0); end
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL rmf_rd_en_in_reset: got %b expected 0", fifo_rd_en); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmf_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmf_busy: got %b expected 0", busy); end
        checks++; if (seq_num !== 8'h00) begin errors++; $display("[TB] FAIL rmf_seq: got %02h expected 00", seq_num); end
        @(posedge clk);
        #1;
        fifo_q.delete();
        exp_q.delete();
        obs_q.delete();
        exp_seq    = 8'h00;
        prev_stall = 1'b0;
        drive_fifo();
    endtask

    task automatic test_enable_low();
        int p0;
        en = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h70 + i));
        drive_fifo();
        p0 = pop_cnt;
        repeat (20) tick();
        checks++; if (pop_cnt != p0) begin errors++; $display("[TB] FAIL en_low_pops: got %0d expected 0", pop_cnt - p0); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL en_low_tx: got %0d bytes expected 0", obs_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL en_low_busy: got %b expected 0", busy); end
        fifo_q.delete();
        obs_q.delete();
        drive_fifo();
    endtask

    task automatic test_checksum_wrap();
        bit         to;
        logic [7:0] eb, gb, last_b;
        last_b = 8'hXX;
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        en = 1'b1;
        run_until_drained(40, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL wrap_timeout: got %0d bytes expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL wrap_stream: got none expected %02h", eb); end
            else begin gb = obs_q.pop_front(); last_b = gb; if (gb !== eb) begin errors++; $display("[TB] FAIL wrap_stream: got %02h expected %02h", gb, eb); end end
        end
        checks++; if (last_b !== 8'h00) begin errors++; $display("[TB] FAIL wrap_chk: got %02h expected 00", last_b); end
        for (int f = 1; f < 256; f++) begin
            push_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            en = 1'b1;
            run_until_drained(40, to);
            checks++; if (to) begin errors++; $display("[TB] FAIL wrap_loop_timeout: frame %0d got %0d bytes expected %0d", f, obs_q.size(), exp_q.size()); end
            while (exp_q.size() > 0) begin
                eb = exp_q.pop_front();
                checks++;
                if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL wrap_loop_stream: frame %0d got none expected %02h", f, eb); end
                else begin gb = obs_q.pop_front(); if (gb !== eb) begin errors++; $display("[TB] FAIL wrap_loop_stream: frame %0d got %02h expected %02h", f, gb, eb); end end
            end
        end
        checks++; if (seq_num !== 8'h00) begin errors++; $display("[TB] FAIL wrap_seq: got %02h expected 00", seq_num); end
    endtask

    // Test sequence
    initial begin
        rst          = 1'b1;
        en           = 1'b0;
        tx_ready     = 1'b1;
        fifo_rd_vld  = 1'b0;
        fifo_rd_data = 8'h00;
        test_reset();
        test_basic_frame();
        test_second_frame();
        test_back_to_back();
        test_backpressure();
        test_underflow();
        test_reset_mid_frame();
        test_enable_low();
        test_checksum_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
